serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor. It replaces the fixed 4-bit ripple add/sub datapath with a WIDTH-bit operation that uses one full-adder cell and processes one bit per clock. A start/busy/done handshake drives it, and it returns a registered result with carry, overflow and zero flags. It sits behind switch/register front-ends and feeds LED/display or accumulator logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b (two's complement); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress (RUN or DONE)
done  output  1  one-cycle pulse, result and flags valid
result  output  WIDTH  sum/difference, held until next accepted start
carry_out  output  1  final carry; for subtraction 1 = no borrow
overflow  output  1  signed overflow, = carry into MSB XOR carry out of MSB
zero  output  1  result == 0

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; busy, done, result, carry_out, overflow and zero are all 0. Reset has priority over everything, including mid-operation. Any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge k, the block latches:
  - a into shift register A
  - b XOR {WIDTH{sub}} into shift register B
  - carry register = sub
  - bit counter = 0
  - It then goes to RUN. busy rises after edge k.
  - In the same edge it clears result, carry_out, overflow and zero to 0.
- RUN: each edge computes one bit, LSB first, via the full-adder cell:
  - s = A[0]^B[0]^c
  - c' = majority(A[0], B[0], c)
  - s shifts into result from the MSB side; A and B shift right.
  - The counter increments.
  - At the edge that processes bit WIDTH-1 (edge k+WIDTH), it captures the carry into bit WIDTH-1 (the carry register before update) for the overflow calculation and goes to DONE.
- DONE: lasts exactly one cycle, after edge k+WIDTH.
  - done=1 and busy=1; result, carry_out, overflow and zero are valid.
  - The next edge returns to IDLE with done=0.
- Latency: start sampled at edge k gives done high from edge k+WIDTH to edge k+WIDTH+1. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored; it is not queued. Operands changing during RUN have no effect.
- Outputs hold after DONE until the next accepted start or reset.
- zero is computed combinationally from the registered result but is gated to 0 unless the result is valid (DONE, or IDLE after a completed operation).
- Arithmetic: modulo 2^WIDTH, with no saturation. The counter width is $clog2(WIDTH+1).

Decomposition:
- Shared package addsub_pkg:
  - state typedef {IDLE, RUN, DONE}
  - MIN_WIDTH=2 and MAX_WIDTH=32 constants for elaboration-time checks
- Sub-module full_adder_1b:
  - ports a, b, cin, s, cout
  - purely combinational, instantiated once
- The FSM, shift registers and flags live in serial_addsub.

Test Plan:
- WIDTH=8: a=100, b=27, sub=0, start -> done exactly 8 cycles after the start edge; result=127 (0x7F), carry_out=0, overflow=0, zero=0.
- WIDTH=8: a=100, b=28, sub=0 -> result=0x80, carry_out=0, overflow=1. Then a=0x80, b=1, sub=1 -> result=0x7F, carry_out=1, overflow=1.
- WIDTH=8: a=5, b=7, sub=1 -> result=0xFE, carry_out=0 (borrow), overflow=0. Then a=7, b=7, sub=1 -> result=0, zero=1, carry_out=1.
- WIDTH=4: a=0xF, b=0x1, sub=0 -> result=0x0, carry_out=1, overflow=0, zero=1. Also a=0x7, b=0x1 -> result=0x8, overflow=1.
- Handshake: assert start with a=3, b=4, then pulse start with a=9, b=9 during RUN and during DONE -> single done pulse, result=7. The second request is ignored; a start after returning to IDLE is accepted.
- Reset mid-operation: start 8-bit op, assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, result=0, all flags 0. No done pulse ever appears; a subsequent start works normally.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and width limits for the bit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit full-adder cell shared by every bit position of the serial datapath.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// WIDTH-bit adder/subtractor that computes one bit per clock, LSB first,
// using one full-adder cell behind a start/busy/done handshake.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_addsub: WIDTH must lie in 2..32");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               fa_s;
    logic               fa_cout;

    full_adder_1b u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                    a_d         = a;
                    b_d         = b ^ {WIDTH{sub}};
                    carry_d     = sub;
                    cnt_d       = '0;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    valid_d     = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                carry_d  = fa_cout;
                result_d = {fa_s, result_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB.
                    carry_out_d = fa_cout;
                    overflow_d  = carry_q ^ fa_cout;
                    valid_d     = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = valid_q && (result_q == '0);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: directed operations on 8-bit and 4-bit instances, expected
// responses queued at issue time and checked by per-instance done monitors.
module tb_serial_addsub;

    logic clk;
    logic rst;

    logic       start8, sub8, busy8, done8, co8, ov8, z8;
    logic [7:0] a8, b8, res8;
    logic       start4, sub4, busy4, done4, co4, ov4, z4;
    logic [3:0] a4, b4, res4;

    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       z;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .carry_out(co8),
        .overflow(ov8), .zero(z8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .carry_out(co4),
        .overflow(ov4), .zero(z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Monitor for the 8-bit instance.
    initial begin
        forever begin
            @(negedge clk);
            if (done8) begin
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL w8_unexpected_done: got done with result=%h, required no done", res8);
                end else begin
                    e8 = q8.pop_front();
                    $display("w8 txn: result=%h co=%b ov=%b z=%b latency=%0d", res8, co8, ov8, z8, cyc - e8.cyc);
                    chk("w8_result_flags", {20'd0, res8, co8, ov8, z8, 1'b0},
                        {20'd0, e8.res, e8.co, e8.ov, e8.z, 1'b0});
                    chk("w8_latency", cyc - e8.cyc, 8);
                end
            end
        end
    end

    // Monitor for the 4-bit instance.
    initial begin
        forever begin
            @(negedge clk);
            if (done4) begin
                if (q4.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL w4_unexpected_done: got done with result=%h, required no done", res4);
                end else begin
                    e4 = q4.pop_front();
                    $display("w4 txn: result=%h co=%b ov=%b z=%b latency=%0d", res4, co4, ov4, z4, cyc - e4.cyc);
                    chk("w4_result_flags", {24'd0, res4, co4, ov4, z4},
                        {24'd0, e4.res[3:0], e4.co, e4.ov, e4.z});
                    chk("w4_latency", cyc - e4.cyc, 4);
                end
            end
        end
    end

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                          input bit push, input logic [7:0] r, input logic co,
                          input logic ov, input logic z);
        exp_t e;
        @(negedge clk);
        a8 = av; b8 = bv; sub8 = s; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        e.res = r; e.co = co; e.ov = ov; e.z = z; e.cyc = cyc;
        if (push) q8.push_back(e);
    endtask

    task automatic issue4(input logic [3:0] av, input logic [3:0] bv, input logic s,
                          input logic [3:0] r, input logic co, input logic ov, input logic z);
        exp_t e;
        @(negedge clk);
        a4 = av; b4 = bv; sub4 = s; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        e.res = {4'd0, r}; e.co = co; e.ov = ov; e.z = z; e.cyc = cyc;
        q4.push_back(e);
    endtask

    task automatic wait_idle(input bit w8);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((w8 ? busy8 : busy4) && n < 40);
        if (w8 ? busy8 : busy4) chk(w8 ? "w8_idle_timeout" : "w4_idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        cyc = 0; n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
        start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("w8_reset_outputs", {26'd0, busy8, done8, co8, ov8, z8, |res8}, 0);
        chk("w4_reset_outputs", {26'd0, busy4, done4, co4, ov4, z4, |res4}, 0);

        // 8-bit arithmetic vectors
        issue8(8'd100, 8'd27, 0, 1, 8'h7F, 0, 0, 0);
        @(negedge clk);
        chk("w8_busy_in_run", {31'd0, busy8}, 1);
        chk("w8_zero_gated_in_run", {31'd0, z8}, 0);
        wait_idle(1);
        issue8(8'd100, 8'd28, 0, 1, 8'h80, 0, 1, 0); wait_idle(1);
        issue8(8'h80,  8'h01, 1, 1, 8'h7F, 1, 1, 0); wait_idle(1);
        issue8(8'd5,   8'd7,  1, 1, 8'hFE, 0, 0, 0); wait_idle(1);
        issue8(8'd7,   8'd7,  1, 1, 8'h00, 1, 0, 1); wait_idle(1);
        chk("w8_zero_held_in_idle", {31'd0, z8}, 1);
        issue8(8'hFF,  8'h01, 0, 1, 8'h00, 1, 0, 1); wait_idle(1);

        // 4-bit vectors
        issue4(4'hF, 4'h1, 0, 4'h0, 1, 0, 1); wait_idle(0);
        issue4(4'h7, 4'h1, 0, 4'h8, 0, 1, 0); wait_idle(0);

        // Starts during RUN and DONE must be ignored
        issue8(8'd3, 8'd4, 0, 1, 8'd7, 0, 0, 0);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        repeat (2) @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) chk("w8_done_timeout", 1, 0);
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        chk("w8_ignored_start_in_done", {31'd0, busy8}, 0);
        chk("w8_result_held", {24'd0, res8}, 7);
        issue8(8'd9, 8'd9, 0, 1, 8'h12, 0, 0, 0); wait_idle(1);

        // Reset during the fourth RUN cycle
        issue8(8'hFF, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("w8_mid_reset_outputs", {26'd0, busy8, done8, co8, ov8, z8, |res8}, 0);
        repeat (12) @(negedge clk);
        chk("w8_stays_idle_after_reset", {31'd0, busy8}, 0);
        issue8(8'h10, 8'h20, 0, 1, 8'h30, 0, 0, 0); wait_idle(1);

        repeat (4) @(negedge clk);
        chk("w8_queue_drained", q8.size(), 0);
        chk("w4_queue_drained", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
